// File: rtl/mapa_pkg.sv
// Shared types for the occupancy-grid request scheduler.
//   TAM_DIST             : width of every position/distance field
//   LARG_ERROS           : width of the saturating timeout counter
//   leitura_t            : one sensor/pose reading (FIFO entry and request payload)
//   estado_escalonador_t : scheduler FSM states
package mapa_pkg;

  localparam int unsigned TAM_DIST   = 8;
  localparam int unsigned LARG_ERROS = 8;

  typedef struct packed {
    logic [TAM_DIST-1:0] x;
    logic [TAM_DIST-1:0] y;
    logic                direcao;
    logic [TAM_DIST-1:0] frente;
    logic [TAM_DIST-1:0] direita;
    logic [TAM_DIST-1:0] esquerda;
  } leitura_t;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    AGUARDA_INICIO = 2'd1,
    AGUARDA_FIM    = 2'd2
  } estado_escalonador_t;

endpackage

// File: rtl/fila_leituras.sv
// Synchronous FIFO of leitura_t readings.
//   clock, reset  : clock, synchronous active-high reset
//   push, pop     : write / read requests (ignored when full / empty)
//   dado_entrada  : entry written on push
//   dado_saida    : head entry (valid when not empty)
//   cheia, vazia  : full / empty flags decoded from the occupancy register
//   ocupacao      : number of stored entries
module fila_leituras
  import mapa_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  leitura_t                        dado_entrada,
  output leitura_t                        dado_saida,
  output logic                            cheia,
  output logic                            vazia,
  output logic [$clog2(PROFUNDIDADE):0]   ocupacao
);

  localparam int unsigned LARG_PTR  = $clog2(PROFUNDIDADE);
  localparam int unsigned LARG_OCUP = LARG_PTR + 1;

  leitura_t            mem [PROFUNDIDADE];
  logic [LARG_PTR-1:0] ptr_escrita;
  logic [LARG_PTR-1:0] ptr_leitura;
  logic                push_ef;
  logic                pop_ef;

  assign cheia      = (ocupacao == LARG_OCUP'(PROFUNDIDADE));
  assign vazia      = (ocupacao == '0);
  assign push_ef    = push && !cheia;
  assign pop_ef     = pop && !vazia;
  assign dado_saida = mem[ptr_leitura];

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_escrita <= '0;
      ptr_leitura <= '0;
      ocupacao    <= '0;
    end else begin
      if (push_ef) ptr_escrita <= ptr_escrita + LARG_PTR'(1);
      if (pop_ef)  ptr_leitura <= ptr_leitura + LARG_PTR'(1);
      case ({push_ef, pop_ef})
        2'b10:   ocupacao <= ocupacao + LARG_OCUP'(1);
        2'b01:   ocupacao <= ocupacao - LARG_OCUP'(1);
        default: ocupacao <= ocupacao;
      endcase
    end
  end

  // Storage needs no reset; only entries behind valid pointers are read.
  always_ff @(posedge clock) begin
    if (!reset && push_ef) mem[ptr_escrita] <= dado_entrada;
  end

endmodule

// File: rtl/escalonador_mapa.sv
// Scheduler that buffers readings and issues them one at a time to the
// occupancy-grid builder, with a watchdog on each handshake wait.
//   clock, reset          : clock, synchronous active-high reset
//   leituraValida/Pronta  : producer handshake (Pronta = FIFO not full)
//   posX..dEsquerda       : reading captured on push
//   operacaoFinalizada    : builder idle/done flag
//   novoDado              : one-cycle request pulse
//   mapa*                 : request fields, change only on a pop
//   ocupado               : FSM not idle
//   ocupacaoFila          : FIFO occupancy
//   erroTimeout           : one-cycle pulse on watchdog expiry
//   contErros             : saturating count of timeouts
module escalonador_mapa
  import mapa_pkg::*;
#(
  parameter int unsigned tamanhoDistancia = TAM_DIST,
  parameter int unsigned ProfundidadeFila = 4,
  parameter int unsigned LimiteEspera     = 1024
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              leituraValida,
  output logic                              leituraPronta,
  input  logic [tamanhoDistancia-1:0]       posX,
  input  logic [tamanhoDistancia-1:0]       posY,
  input  logic                              direcao,
  input  logic [tamanhoDistancia-1:0]       dFrente,
  input  logic [tamanhoDistancia-1:0]       dDireita,
  input  logic [tamanhoDistancia-1:0]       dEsquerda,
  input  logic                              operacaoFinalizada,
  output logic                              novoDado,
  output logic [tamanhoDistancia-1:0]       mapaPosX,
  output logic [tamanhoDistancia-1:0]       mapaPosY,
  output logic                              mapaDirecao,
  output logic [tamanhoDistancia-1:0]       mapaFrente,
  output logic [tamanhoDistancia-1:0]       mapaDireita,
  output logic [tamanhoDistancia-1:0]       mapaEsquerda,
  output logic                              ocupado,
  output logic [$clog2(ProfundidadeFila):0] ocupacaoFila,
  output logic                              erroTimeout,
  output logic [LARG_ERROS-1:0]             contErros
);

  localparam int unsigned LARG_WD = $clog2(LimiteEspera);

  estado_escalonador_t  estado, estado_prox;
  logic [LARG_WD-1:0]   wd, wd_prox;
  logic [LARG_ERROS-1:0] erros_prox;
  logic                 novo_prox;
  logic                 erro_prox;
  logic                 pop;
  logic                 expirou;
  logic                 cheia;
  logic                 vazia;
  leitura_t             entrada;
  leitura_t             cabeca;
  leitura_t             mapa_reg;

  assign entrada.x        = TAM_DIST'(posX);
  assign entrada.y        = TAM_DIST'(posY);
  assign entrada.direcao  = direcao;
  assign entrada.frente   = TAM_DIST'(dFrente);
  assign entrada.direita  = TAM_DIST'(dDireita);
  assign entrada.esquerda = TAM_DIST'(dEsquerda);

  assign leituraPronta = !cheia;

  fila_leituras #(
    .PROFUNDIDADE (ProfundidadeFila)
  ) u_fila (
    .clock        (clock),
    .reset        (reset),
    .push         (leituraValida),
    .pop          (pop),
    .dado_entrada (entrada),
    .dado_saida   (cabeca),
    .cheia        (cheia),
    .vazia        (vazia),
    .ocupacao     (ocupacaoFila)
  );

  // Next state, pop strobe, watchdog and error counter.
  always_comb begin
    estado_prox = estado;
    wd_prox     = wd;
    erros_prox  = contErros;
    novo_prox   = 1'b0;
    erro_prox   = 1'b0;
    pop         = 1'b0;
    // wd holds the cycles already spent in the wait state, so this is the
    // cycle where the count reaches LimiteEspera.
    expirou     = (wd == LARG_WD'(LimiteEspera - 1));

    case (estado)
      IDLE: begin
        if (!vazia && operacaoFinalizada) begin
          pop         = 1'b1;
          novo_prox   = 1'b1;
          wd_prox     = '0;
          estado_prox = AGUARDA_INICIO;
        end
      end
      AGUARDA_INICIO, AGUARDA_FIM: begin
        wd_prox = wd + LARG_WD'(1);
        if (expirou) begin
          erro_prox   = 1'b1;
          wd_prox     = '0;
          estado_prox = IDLE;
          if (contErros != '1) erros_prox = contErros + LARG_ERROS'(1);
        end else if (estado == AGUARDA_INICIO && !operacaoFinalizada) begin
          wd_prox     = '0;
          estado_prox = AGUARDA_FIM;
        end else if (estado == AGUARDA_FIM && operacaoFinalizada) begin
          estado_prox = IDLE;
        end
      end
      default: estado_prox = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= IDLE;
      wd          <= '0;
      contErros   <= '0;
      novoDado    <= 1'b0;
      erroTimeout <= 1'b0;
      ocupado     <= 1'b0;
      mapa_reg    <= '0;
    end else begin
      estado      <= estado_prox;
      wd          <= wd_prox;
      contErros   <= erros_prox;
      novoDado    <= novo_prox;
      erroTimeout <= erro_prox;
      ocupado     <= (estado_prox != IDLE);
      if (pop) mapa_reg <= cabeca;
    end
  end

  assign mapaPosX     = tamanhoDistancia'(mapa_reg.x);
  assign mapaPosY     = tamanhoDistancia'(mapa_reg.y);
  assign mapaDirecao  = mapa_reg.direcao;
  assign mapaFrente   = tamanhoDistancia'(mapa_reg.frente);
  assign mapaDireita  = tamanhoDistancia'(mapa_reg.direita);
  assign mapaEsquerda = tamanhoDistancia'(mapa_reg.esquerda);

endmodule

// File: tb/tb_escalonador_mapa.sv
// Self-checking bench for escalonador_mapa: table-driven burst plus
// hand-written multi-cycle sequences, with a scoreboard on delivered requests.
module tb_escalonador_mapa;
  import mapa_pkg::*;

  localparam int unsigned PROF      = 4;
  localparam int unsigned LIMITE    = 16;
  localparam int unsigned LARG_OCUP = $clog2(PROF) + 1;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  leituraValida;
  logic                  leituraPronta;
  logic [TAM_DIST-1:0]   posX, posY, dFrente, dDireita, dEsquerda;
  logic                  direcao;
  logic                  operacaoFinalizada;
  logic                  novoDado;
  logic [TAM_DIST-1:0]   mapaPosX, mapaPosY, mapaFrente, mapaDireita, mapaEsquerda;
  logic                  mapaDirecao;
  logic                  ocupado;
  logic [LARG_OCUP-1:0]  ocupacaoFila;
  logic                  erroTimeout;
  logic [LARG_ERROS-1:0] contErros;

  // Builder model control: manual level or automatic handshake.
  logic auto_on    = 1'b0;
  logic fim_manual = 1'b1;
  logic fim_modelo = 1'b1;
  int   espera     = 0;
  int   hold       = 0;

  assign operacaoFinalizada = auto_on ? fim_modelo : fim_manual;

  int n_vec = 0;
  int n_err = 0;
  int n_pulsos = 0;
  logic novo_ant = 1'b0;
  leitura_t sb[$];
  leitura_t esperado, obtido;

  typedef struct {
    leitura_t    r;
    int unsigned ocup;
    logic        pronto;
  } vetor_t;
  vetor_t tab [4];

  escalonador_mapa #(
    .tamanhoDistancia (TAM_DIST),
    .ProfundidadeFila (PROF),
    .LimiteEspera     (LIMITE)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .leituraValida      (leituraValida),
    .leituraPronta      (leituraPronta),
    .posX               (posX),
    .posY               (posY),
    .direcao            (direcao),
    .dFrente            (dFrente),
    .dDireita           (dDireita),
    .dEsquerda          (dEsquerda),
    .operacaoFinalizada (operacaoFinalizada),
    .novoDado           (novoDado),
    .mapaPosX           (mapaPosX),
    .mapaPosY           (mapaPosY),
    .mapaDirecao        (mapaDirecao),
    .mapaFrente         (mapaFrente),
    .mapaDireita        (mapaDireita),
    .mapaEsquerda       (mapaEsquerda),
    .ocupado            (ocupado),
    .ocupacaoFila       (ocupacaoFila),
    .erroTimeout        (erroTimeout),
    .contErros          (contErros)
  );

  always #5 clock = ~clock;

  task automatic verifica(input string nome, input logic [63:0] obtido_v, input logic [63:0] esperado_v);
    n_vec++;
    if (obtido_v !== esperado_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, obtido_v, esperado_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic leitura_t mk(input int unsigned x, y, d, f, di, e);
    leitura_t r;
    r.x        = TAM_DIST'(x);
    r.y        = TAM_DIST'(y);
    r.direcao  = 1'(d);
    r.frente   = TAM_DIST'(f);
    r.direita  = TAM_DIST'(di);
    r.esquerda = TAM_DIST'(e);
    return r;
  endfunction

  task automatic dirige(input leitura_t r);
    posX = r.x; posY = r.y; direcao = r.direcao;
    dFrente = r.frente; dDireita = r.direita; dEsquerda = r.esquerda;
  endtask

  // Holds leituraValida until accepted; leaves it high for a back-to-back follow-up.
  task automatic empurra(input leitura_t r);
    int unsigned n;
    dirige(r);
    leituraValida = 1'b1;
    n = 0;
    while (!leituraPronta && n < 200) begin
      tick();
      n++;
    end
    if (!leituraPronta) verifica("push_aceito", 64'(leituraPronta), 64'(1));
    else sb.push_back(r);
    tick();
  endtask

  task automatic espera_ocioso(input int unsigned limite);
    int unsigned n;
    n = 0;
    while ((ocupado || ocupacaoFila != '0) && n < limite) begin
      tick();
      n++;
    end
    verifica("ocioso_ocupado", 64'(ocupado), 64'(0));
    verifica("ocioso_fila", 64'(ocupacaoFila), 64'(0));
  endtask

  // Builder model: drop done one cycle after the request, raise it 10 cycles later.
  always begin
    @(posedge clock);
    #1;
    if (!auto_on) begin
      espera     = 0;
      fim_modelo = 1'b1;
    end else if (espera == 0) begin
      if (novoDado) espera = 1;
    end else if (espera == 1) begin
      fim_modelo = 1'b0;
      hold       = 10;
      espera     = 2;
    end else begin
      hold--;
      if (hold == 0) begin
        fim_modelo = 1'b1;
        espera     = 0;
      end
    end
  end

  // Scoreboard: each request pulse must match the oldest accepted reading.
  always @(negedge clock) begin
    if (novoDado) begin
      n_pulsos++;
      verifica("novoDado_um_ciclo", 64'(novo_ant), 64'(0));
      if (sb.size() == 0) begin
        verifica("novoDado_inesperado", 64'(novoDado), 64'(0));
      end else begin
        esperado         = sb.pop_front();
        obtido.x         = mapaPosX;
        obtido.y         = mapaPosY;
        obtido.direcao   = mapaDirecao;
        obtido.frente    = mapaFrente;
        obtido.direita   = mapaDireita;
        obtido.esquerda  = mapaEsquerda;
        verifica("mapa_campos", 64'(obtido), 64'(esperado));
      end
    end
    novo_ant = novoDado;
  end

  initial begin
    int pulsos_base;
    leitura_t ra, rb, rc, rd;

    tab[0] = '{r: mk(10, 11, 0, 12, 13, 14), ocup: 1, pronto: 1'b1};
    tab[1] = '{r: mk(20, 21, 1, 22, 23, 24), ocup: 2, pronto: 1'b1};
    tab[2] = '{r: mk(30, 31, 0, 32, 33, 34), ocup: 3, pronto: 1'b1};
    tab[3] = '{r: mk(40, 41, 1, 42, 43, 44), ocup: 4, pronto: 1'b0};

    reset = 1'b1;
    leituraValida = 1'b0;
    dirige(mk(0, 0, 0, 0, 0, 0));
    tick();
    tick();
    verifica("rst_pronta", 64'(leituraPronta), 64'(1));
    verifica("rst_novoDado", 64'(novoDado), 64'(0));
    verifica("rst_ocupado", 64'(ocupado), 64'(0));
    verifica("rst_fila", 64'(ocupacaoFila), 64'(0));
    verifica("rst_erro", 64'(erroTimeout), 64'(0));
    verifica("rst_contErros", 64'(contErros), 64'(0));
    verifica("rst_mapaPosX", 64'(mapaPosX), 64'(0));
    reset = 1'b0;
    tick();

    // Single request with automatic builder.
    auto_on = 1'b1;
    empurra(mk(3, 4, 0, 5, 2, 1));
    leituraValida = 1'b0;
    verifica("t1_fila", 64'(ocupacaoFila), 64'(1));
    verifica("t1_sem_fallthrough", 64'(novoDado), 64'(0));
    tick();
    verifica("t1_novoDado", 64'(novoDado), 64'(1));
    verifica("t1_mapaPosX", 64'(mapaPosX), 64'(3));
    verifica("t1_mapaDireita", 64'(mapaDireita), 64'(2));
    verifica("t1_ocupado", 64'(ocupado), 64'(1));
    tick();
    verifica("t1_novoDado_baixo", 64'(novoDado), 64'(0));
    espera_ocioso(100);
    verifica("t1_mapa_estavel", 64'(mapaPosX), 64'(3));

    // Burst with backpressure, table-driven.
    auto_on = 1'b0;
    fim_manual = 1'b0;
    pulsos_base = n_pulsos;
    for (int i = 0; i < 4; i++) begin
      empurra(tab[i].r);
      verifica("t2_fila", 64'(ocupacaoFila), 64'(tab[i].ocup));
      verifica("t2_pronta", 64'(leituraPronta), 64'(tab[i].pronto));
    end
    dirige(mk(50, 51, 0, 52, 53, 54));
    tick();
    tick();
    tick();
    verifica("t2_fila_cheia", 64'(ocupacaoFila), 64'(4));
    verifica("t2_pronta_cheia", 64'(leituraPronta), 64'(0));
    fim_manual = 1'b1;
    auto_on = 1'b1;
    empurra(mk(50, 51, 0, 52, 53, 54));
    empurra(mk(60, 61, 1, 62, 63, 64));
    leituraValida = 1'b0;
    espera_ocioso(400);
    verifica("t2_entregues", 64'(n_pulsos - pulsos_base), 64'(6));

    // Push on the same edge as a pop.
    auto_on = 1'b0;
    fim_manual = 1'b0;
    ra = mk(70, 71, 0, 72, 73, 74);
    rb = mk(80, 81, 1, 82, 83, 84);
    empurra(ra);
    verifica("t3_fila_antes", 64'(ocupacaoFila), 64'(1));
    fim_manual = 1'b1;
    auto_on = 1'b1;
    empurra(rb);
    leituraValida = 1'b0;
    verifica("t3_fila_simult", 64'(ocupacaoFila), 64'(1));
    verifica("t3_novoDado", 64'(novoDado), 64'(1));
    verifica("t3_mapaPosX", 64'(mapaPosX), 64'(70));
    espera_ocioso(100);

    // Timeout with done stuck high; the queued entry goes out next.
    auto_on = 1'b0;
    fim_manual = 1'b1;
    rc = mk(90, 91, 0, 92, 93, 94);
    rd = mk(100, 101, 1, 102, 103, 104);
    empurra(rc);
    empurra(rd);
    leituraValida = 1'b0;
    verifica("t4_novoDado_c", 64'(novoDado), 64'(1));
    verifica("t4_mapaPosX_c", 64'(mapaPosX), 64'(90));
    for (int i = 0; i < 15; i++) begin
      tick();
      verifica("t4_erro_cedo", 64'(erroTimeout), 64'(0));
    end
    verifica("t4_ocupado_espera", 64'(ocupado), 64'(1));
    tick();
    verifica("t4_erro_pulso", 64'(erroTimeout), 64'(1));
    verifica("t4_contErros1", 64'(contErros), 64'(1));
    verifica("t4_ocupado_idle", 64'(ocupado), 64'(0));
    tick();
    verifica("t4_erro_um_ciclo", 64'(erroTimeout), 64'(0));
    verifica("t4_novoDado_d", 64'(novoDado), 64'(1));
    verifica("t4_mapaPosX_d", 64'(mapaPosX), 64'(100));
    for (int i = 0; i < 16; i++) tick();
    verifica("t4_erro_pulso_d", 64'(erroTimeout), 64'(1));
    verifica("t4_contErros2", 64'(contErros), 64'(2));
    tick();

    // Reset while waiting for completion with two entries queued.
    fim_manual = 1'b1;
    auto_on = 1'b1;
    empurra(mk(110, 111, 0, 112, 113, 114));
    empurra(mk(120, 121, 1, 122, 123, 124));
    empurra(mk(130, 131, 0, 132, 133, 134));
    leituraValida = 1'b0;
    tick();
    verifica("t5_ocupado", 64'(ocupado), 64'(1));
    verifica("t5_fila", 64'(ocupacaoFila), 64'(2));
    reset = 1'b1;
    auto_on = 1'b0;
    sb.delete();
    pulsos_base = n_pulsos;
    tick();
    verifica("t5_novoDado", 64'(novoDado), 64'(0));
    verifica("t5_fila_vazia", 64'(ocupacaoFila), 64'(0));
    verifica("t5_ocupado_rst", 64'(ocupado), 64'(0));
    verifica("t5_pronta", 64'(leituraPronta), 64'(1));
    verifica("t5_contErros", 64'(contErros), 64'(0));
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    verifica("t5_sem_pedidos", 64'(n_pulsos - pulsos_base), 64'(0));
    verifica("t5_ocioso", 64'(ocupado), 64'(0));

    // Saturation of the timeout counter.
    auto_on = 1'b0;
    fim_manual = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int n;
      empurra(mk(i % 256, (i * 7) % 256, i % 2, 1, 2, 3));
      leituraValida = 1'b0;
      n = 0;
      while (!erroTimeout && n < 40) begin
        tick();
        n++;
      end
      verifica("t6_timeout", 64'(erroTimeout), 64'(1));
      verifica("t6_contErros", 64'(contErros), 64'((i + 1 > 255) ? 255 : i + 1));
    end
    tick();
    verifica("t6_satura", 64'(contErros), 64'(255));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
